rtc_bus_ctrl: RTL and testbench

Bus-side transaction engine for the multiplexed address/data interface of the external real-time clock chip. It runs one complete RTC register write or read per request, with programmable phase timing. For a read it returns the captured byte together with a one-cycle completion pulse. It sits between the PicoBlaze-facing RTC register block and the RTC chip pins, and drives the physical protocol that the register block only requests.

---
 rtl/rtc_bus_ctrl_if.sv | 28 ++
 rtl/rtc_bus_ctrl.sv | 155 +++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_ctrl_if.sv
// Bundle of request/response signals and RTC pin signals around rtc_bus_ctrl.
// The master side is the register block plus the pad ring; the slave side is the engine.
interface rtc_bus_ctrl_if;
   logic       start_wr;
   logic       start_rd;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic       cs_n;
   logic       ad_sel;
   logic       wr_n;
   logic       rd_n;
   logic [7:0] ad_out;
   logic       ad_oe;
   logic [7:0] ad_in;

   modport master (
      output start_wr, start_rd, addr, wdata, ad_in,
      input  rdata, busy, done, cs_n, ad_sel, wr_n, rd_n, ad_out, ad_oe
   );

   modport slave (
      input  start_wr, start_rd, addr, wdata, ad_in,
      output rdata, busy, done, cs_n, ad_sel, wr_n, rd_n, ad_out, ad_oe
   );
endinterface

// File: rtl/rtc_bus_ctrl.sv
// Transaction engine for the RTC chip's multiplexed A/D bus: one register write or
// read per request, each bus phase lasting PHASE_CYC clocks, all outputs registered.
module rtc_bus_ctrl #(
   parameter int unsigned PHASE_CYC = 10
) (
   input  logic            clk,
   input  logic            reset,
   rtc_bus_ctrl_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A_SET = 3'd1,
      A_STB = 3'd2,
      A_HLD = 3'd3,
      D_SET = 3'd4,
      D_STB = 3'd5,
      D_HLD = 3'd6,
      FIN   = 3'd7
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(PHASE_CYC - 1);

   state_t     state, state_nx;
   logic [7:0] cnt, cnt_nx;
   logic [7:0] addr_q, addr_nx;
   logic [7:0] wdata_q, wdata_nx;
   logic       is_rd_q, is_rd_nx;
   logic       phase_end;

   logic [7:0] rdata_q, rdata_nx;
   logic       busy_q, busy_nx;
   logic       done_q, done_nx;
   logic       cs_n_q, cs_n_nx;
   logic       ad_sel_q, ad_sel_nx;
   logic       wr_n_q, wr_n_nx;
   logic       rd_n_q, rd_n_nx;
   logic [7:0] ad_out_q, ad_out_nx;
   logic       ad_oe_q, ad_oe_nx;

   assign phase_end = (cnt == LAST_CNT);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      addr_nx  = addr_q;
      wdata_nx = wdata_q;
      is_rd_nx = is_rd_q;
      rdata_nx = rdata_q;

      case (state)
         IDLE: begin
            if (bus.start_wr || bus.start_rd) begin
               state_nx = A_SET;
               cnt_nx   = 8'd0;
               addr_nx  = bus.addr;
               wdata_nx = bus.wdata;
               // simultaneous requests resolve to a write
               is_rd_nx = bus.start_rd && !bus.start_wr;
            end
         end
         FIN: state_nx = IDLE;
         default: begin
            if (phase_end) begin
               cnt_nx   = 8'd0;
               state_nx = state_t'(state + 3'd1);
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
      endcase

      if (state == D_STB && phase_end && is_rd_q)
         rdata_nx = bus.ad_in;
   end

   // Outputs are decoded from the next state so the registered pins line up with it.
   always_comb begin
      busy_nx   = 1'b1;
      done_nx   = 1'b0;
      cs_n_nx   = 1'b1;
      ad_sel_nx = 1'b0;
      wr_n_nx   = 1'b1;
      rd_n_nx   = 1'b1;
      ad_out_nx = 8'h00;
      ad_oe_nx  = 1'b0;

      case (state_nx)
         IDLE: busy_nx = 1'b0;
         A_SET, A_STB, A_HLD: begin
            cs_n_nx   = 1'b0;
            ad_oe_nx  = 1'b1;
            ad_out_nx = addr_nx;
            wr_n_nx   = (state_nx != A_STB);
         end
         D_SET, D_STB, D_HLD: begin
            cs_n_nx   = 1'b0;
            ad_sel_nx = 1'b1;
            ad_oe_nx  = !is_rd_nx;
            ad_out_nx = is_rd_nx ? 8'h00 : wdata_nx;
            if (state_nx == D_STB) begin
               wr_n_nx = is_rd_nx;
               rd_n_nx = !is_rd_nx;
            end
         end
         FIN: done_nx = 1'b1;
         default: busy_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
         is_rd_q  <= 1'b0;
         rdata_q  <= 8'h00;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cs_n_q   <= 1'b1;
         ad_sel_q <= 1'b0;
         wr_n_q   <= 1'b1;
         rd_n_q   <= 1'b1;
         ad_out_q <= 8'h00;
         ad_oe_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         addr_q   <= addr_nx;
         wdata_q  <= wdata_nx;
         is_rd_q  <= is_rd_nx;
         rdata_q  <= rdata_nx;
         busy_q   <= busy_nx;
         done_q   <= done_nx;
         cs_n_q   <= cs_n_nx;
         ad_sel_q <= ad_sel_nx;
         wr_n_q   <= wr_n_nx;
         rd_n_q   <= rd_n_nx;
         ad_out_q <= ad_out_nx;
         ad_oe_q  <= ad_oe_nx;
      end
   end

   assign bus.rdata  = rdata_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.cs_n   = cs_n_q;
   assign bus.ad_sel = ad_sel_q;
   assign bus.wr_n   = wr_n_q;
   assign bus.rd_n   = rd_n_q;
   assign bus.ad_out = ad_out_q;
   assign bus.ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: three instances (PHASE_CYC 2, 1, 10) checked every cycle
// against a transaction-level model, plus literal checks of the P=2 waveforms.
module tb_rtc_bus_ctrl;
   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic       s_rst   [3];
   logic       s_wr    [3];
   logic       s_rd    [3];
   logic [7:0] s_addr  [3];
   logic [7:0] s_wdata [3];
   logic [7:0] s_adin  [3];
   logic [22:0] out_vec [3];

   rtc_bus_ctrl_if b0 ();
   rtc_bus_ctrl_if b1 ();
   rtc_bus_ctrl_if b2 ();

   assign b0.start_wr = s_wr[0];  assign b0.start_rd = s_rd[0];
   assign b0.addr = s_addr[0];    assign b0.wdata = s_wdata[0];  assign b0.ad_in = s_adin[0];
   assign b1.start_wr = s_wr[1];  assign b1.start_rd = s_rd[1];
   assign b1.addr = s_addr[1];    assign b1.wdata = s_wdata[1];  assign b1.ad_in = s_adin[1];
   assign b2.start_wr = s_wr[2];  assign b2.start_rd = s_rd[2];
   assign b2.addr = s_addr[2];    assign b2.wdata = s_wdata[2];  assign b2.ad_in = s_adin[2];

   // {rdata, busy, done, cs_n, ad_sel, wr_n, rd_n, ad_out, ad_oe}
   assign out_vec[0] = {b0.rdata, b0.busy, b0.done, b0.cs_n, b0.ad_sel, b0.wr_n, b0.rd_n, b0.ad_out, b0.ad_oe};
   assign out_vec[1] = {b1.rdata, b1.busy, b1.done, b1.cs_n, b1.ad_sel, b1.wr_n, b1.rd_n, b1.ad_out, b1.ad_oe};
   assign out_vec[2] = {b2.rdata, b2.busy, b2.done, b2.cs_n, b2.ad_sel, b2.wr_n, b2.rd_n, b2.ad_out, b2.ad_oe};

   rtc_bus_ctrl #(.PHASE_CYC(2))  dut0 (.clk(clk), .reset(s_rst[0]), .bus(b0));
   rtc_bus_ctrl #(.PHASE_CYC(1))  dut1 (.clk(clk), .reset(s_rst[1]), .bus(b1));
   rtc_bus_ctrl #(.PHASE_CYC(10)) dut2 (.clk(clk), .reset(s_rst[2]), .bus(b2));

   localparam logic [22:0] RST_VEC = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};

   function automatic int pc(input int i);
      case (i)
         0: return 2;
         1: return 1;
         default: return 10;
      endcase
   endfunction

   // Model: t = cycles since acceptance (0 = idle); cycle t of a transaction is in phase (t-1)/P.
   int         t      [3] = '{0, 0, 0};
   int         acc    [3] = '{0, 0, 0};
   logic       m_rd   [3] = '{1'b0, 1'b0, 1'b0};
   logic [7:0] m_addr [3] = '{8'h00, 8'h00, 8'h00};
   logic [7:0] m_wdata[3] = '{8'h00, 8'h00, 8'h00};
   logic [7:0] m_rdata[3] = '{8'h00, 8'h00, 8'h00};
   int         cyc = 0;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int p;
         p = pc(i);
         if (s_rst[i]) begin
            t[i] = 0;
            m_rdata[i] = 8'h00;
         end else if (t[i] == 0) begin
            if (s_wr[i] || s_rd[i]) begin
               m_rd[i]    = s_rd[i] && !s_wr[i];
               m_addr[i]  = s_addr[i];
               m_wdata[i] = s_wdata[i];
               acc[i]     = cyc;
               t[i]       = 1;
            end
         end else if (t[i] == 6 * p + 1) begin
            t[i] = 0;
         end else begin
            if (t[i] == 5 * p && m_rd[i]) m_rdata[i] = s_adin[i];
            t[i] = t[i] + 1;
         end
      end
      cyc = cyc + 1;
   end

   function automatic logic [22:0] exp_vec(input int i);
      int p, tt, ph;
      logic bsy, dn, csn, sel, wrn, rdn, oe;
      logic [7:0] o;
      p = pc(i); tt = t[i]; ph = 0;
      bsy = 1'b0; dn = 1'b0; csn = 1'b1; sel = 1'b0; wrn = 1'b1; rdn = 1'b1; oe = 1'b0; o = 8'h00;
      if (tt >= 1 && tt <= 6 * p) begin
         ph  = (tt - 1) / p;
         bsy = 1'b1;
         csn = 1'b0;
         sel = (ph >= 3);
         wrn = !(ph == 1 || (ph == 4 && !m_rd[i]));
         rdn = !(ph == 4 && m_rd[i]);
         oe  = (ph < 3) || !m_rd[i];
         o   = (ph < 3) ? m_addr[i] : (m_rd[i] ? 8'h00 : m_wdata[i]);
      end else if (tt == 6 * p + 1) begin
         bsy = 1'b1;
         dn  = 1'b1;
      end
      return {m_rdata[i], bsy, dn, csn, sel, wrn, rdn, o, oe};
   endfunction

   int tests = 0;
   int fails = 0;
   int printed = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic compare_all();
      logic [22:0] e, v;
      for (int i = 0; i < 3; i++) begin
         e = exp_vec(i);
         v = out_vec[i];
         tests++;
         if (v !== e) begin
            fails++;
            if (printed < 40) begin
               printed++;
               $display("FAIL model inst%0d cyc%0d: got %h want %h", i, cyc, v, e);
            end
         end
         tests++;
         if ((v[10] === 1'b0 && v[9] === 1'b0) || (v[0] === 1'b1 && v[9] === 1'b0)) begin
            fails++;
            $display("FAIL bus_invariant inst%0d cyc%0d: got %h want no wr_n/rd_n overlap, no ad_oe in rd_n", i, cyc, v);
         end
         if (v[13] === 1'b1) chk($sformatf("latency inst%0d", i), 32'(cyc - acc[i]), 32'(6 * pc(i) + 1));
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare_all();
   endtask

   logic [22:0] snap [0:40];

   // Drives one P=2 request on instance 0 and records cycles 1..n after the request cycle.
   task automatic run0(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d,
                       input int n, input int hold, input int pulse_until, input int rst_at);
      step();
      s_wr[0] = w; s_rd[0] = r; s_addr[0] = a; s_wdata[0] = d; s_adin[0] = 8'($urandom);
      for (int c = 1; c <= n; c++) begin
         step();
         snap[c] = out_vec[0];
         if (c > hold) begin s_wr[0] = 1'b0; s_rd[0] = 1'b0; end
         if (c <= pulse_until) begin s_wr[0] = 1'($urandom); s_rd[0] = 1'($urandom); end
         s_addr[0]  = 8'($urandom);
         s_wdata[0] = 8'($urandom);
         s_rst[0]   = (c == rst_at);
         s_adin[0]  = (c == 9 || c == 10) ? 8'h37 : 8'($urandom);
      end
      s_wr[0] = 1'b0; s_rd[0] = 1'b0; s_rst[0] = 1'b0;
   endtask

   function automatic logic [31:0] mask_of(input int b, input logic val, input int n);
      logic [31:0] m;
      m = 32'h0;
      for (int c = 1; c <= n; c++) if (snap[c][b] === val) m[c] = 1'b1;
      return m;
   endfunction

   initial begin
      for (int i = 0; i < 3; i++) begin
         s_rst[i] = 1'b1; s_wr[i] = 1'b0; s_rd[i] = 1'b0;
         s_addr[i] = 8'h00; s_wdata[i] = 8'h00; s_adin[i] = 8'h00;
      end
      repeat (3) step();
      for (int i = 0; i < 3; i++) s_rst[i] = 1'b0;
      step();
      chk("reset_state", 32'(out_vec[0]), 32'(RST_VEC));

      // write 0x45 to 0x21
      run0(1'b1, 1'b0, 8'h21, 8'h45, 14, 0, 0, 0);
      chk("wr cs_n low cycles", mask_of(12, 1'b0, 14), 32'h0000_1FFE);
      chk("wr wr_n low cycles", mask_of(10, 1'b0, 14), 32'h0000_0618);
      chk("wr rd_n low cycles", mask_of(9, 1'b0, 14), 32'h0);
      chk("wr addr phase bus", {23'h0, snap[3][11], snap[3][8:1]}, 32'h021);
      chk("wr data phase bus", {23'h0, snap[9][11], snap[9][8:1]}, 32'h145);
      chk("wr done cycle", mask_of(13, 1'b1, 14), 32'h0000_2000);
      chk("wr rdata", 32'(snap[13][22:15]), 32'h00);

      // read from 0x05, pad shows 0x37 in D_STB
      run0(1'b0, 1'b1, 8'h05, 8'h00, 16, 0, 0, 0);
      chk("rd rd_n low cycles", mask_of(9, 1'b0, 16), 32'h0000_0600);
      chk("rd wr_n low cycles", mask_of(10, 1'b0, 16), 32'h0000_0018);
      chk("rd ad_oe during rd_n", mask_of(0, 1'b1, 16) & 32'h0000_0600, 32'h0);
      chk("rd done cycle", mask_of(13, 1'b1, 16), 32'h0000_2000);
      chk("rd rdata at done", 32'(snap[13][22:15]), 32'h37);
      chk("rd rdata holds", 32'(snap[16][22:15]), 32'h37);

      // both requests together: a write
      run0(1'b1, 1'b1, 8'h10, 8'hAA, 14, 0, 0, 0);
      chk("both wr_n low cycles", mask_of(10, 1'b0, 14), 32'h0000_0618);
      chk("both rd_n low cycles", mask_of(9, 1'b0, 14), 32'h0);
      chk("both data bus", 32'(snap[9][8:1]), 32'hAA);
      chk("both rdata unchanged", 32'(snap[13][22:15]), 32'h37);

      // requests pulsed while busy are dropped
      run0(1'b1, 1'b0, 8'h33, 8'h44, 20, 0, 12, 0);
      chk("pulsed done count", mask_of(13, 1'b1, 20), 32'h0000_2000);
      chk("pulsed idle after", 32'(snap[20][14]), 32'h0);

      // request held through FIN starts a second transaction
      run0(1'b1, 1'b0, 8'h44, 8'h55, 30, 14, 0, 0);
      chk("held done cycles", mask_of(13, 1'b1, 30), 32'h0800_2000);
      chk("held busy cycles", mask_of(14, 1'b1, 30), 32'h0FFF_BFFE);

      // reset during D_STB of a read
      run0(1'b0, 1'b1, 8'h0C, 8'h00, 20, 0, 0, 9);
      chk("rst_mid outputs", 32'(snap[10]), 32'(RST_VEC));
      chk("rst_mid no done", mask_of(13, 1'b1, 20), 32'h0);
      chk("rst_mid rdata", 32'(snap[20][22:15]), 32'h00);

      // random back-to-back traffic on the P=1 and P=10 instances
      for (int k = 0; k < 3000; k++) begin
         step();
         for (int i = 1; i < 3; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            s_rst[i]   = ($urandom_range(0, 399) == 0);
            s_wr[i]    = (r < 4);
            s_rd[i]    = (r >= 2 && r < 7);
            s_addr[i]  = 8'($urandom);
            s_wdata[i] = 8'($urandom);
            s_adin[i]  = 8'($urandom);
         end
      end
      for (int i = 1; i < 3; i++) begin
         s_wr[i] = 1'b0; s_rd[i] = 1'b0; s_rst[i] = 1'b0;
      end
      repeat (70) step();

      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
